// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2, but never narrower than one bit so counters stay legal.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority search for the first valid requester at or above ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    int k;

    // Scan from the farthest candidate back to ptr so the closest hit wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        k       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (valid_i[k]) begin
                found_o = 1'b1;
                idx_o   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one shared FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int REQ_NUM   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [REQ_NUM-1:0]        req_valid_i,
    input  logic [REQ_NUM*DWIDTH-1:0] req_data_i,
    output logic [REQ_NUM-1:0]        req_ready_o,
    input  logic                      fifo_full_i,
    output logic                      fifo_wr_o,
    output logic [DWIDTH-1:0]         fifo_wrdata_o,
    output logic [REQ_NUM-1:0]        grant_o,
    output logic                      busy_o
);

    localparam int IW = clog2_min1(REQ_NUM);
    localparam int CW = clog2_min1(BURST_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(REQ_NUM - 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] pick_idx;
    logic          pick_found;

    rr_pick #(
        .N  (REQ_NUM),
        .IW (IW)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from state only, so the async reset clears them at once.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gidx_d        = gidx_q;
        cnt_d         = cnt_q;
        req_ready_o   = '0;
        fifo_wr_o     = 1'b0;
        fifo_wrdata_o = '0;
        grant_o       = '0;
        busy_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                busy_o              = 1'b1;
                grant_o[gidx_q]     = 1'b1;
                req_ready_o[gidx_q] = ~fifo_full_i;
                fifo_wr_o           = req_valid_i[gidx_q] & ~fifo_full_i;
                fifo_wrdata_o       = req_data_i[int'(gidx_q)*DWIDTH +: DWIDTH];

                // A drained requester or a full burst both hand the turn onward.
                if (!req_valid_i[gidx_q] || (fifo_wr_o && (cnt_q == CNT_LAST))) begin
                    state_d = IDLE;
                    ptr_d   = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
                end else if (fifo_wr_o) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int BL = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_wrdata;
    logic [3:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic       full;
        logic [3:0] grant;
        logic       wr;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[4][$];
    logic [5:0] seq[4];

    fifo_wr_arbiter #(
        .DWIDTH    (8),
        .REQ_NUM   (4),
        .BURST_LEN (BL)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .fifo_full_i   (fifo_full),
        .fifo_wr_o     (fifo_wr),
        .fifo_wrdata_o (fifo_wrdata),
        .grant_o       (grant),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic f,
                                input logic [3:0] g, input logic w);
        vec_t t;
        t.rst_n = r; t.valid = v; t.full = f; t.grant = g; t.wr = w;
        return t;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic check_all(input string nm, input logic [3:0] g, input logic w,
                             input logic f);
        logic [7:0] ed;
        ed = (g != 4'b0) ? 8'hA0 + 8'(oh2idx(g)) : 8'h00;
        check({nm, " grant"}, int'(grant), int'(g));
        check({nm, " wr"}, int'(fifo_wr), int'(w));
        check({nm, " ready"}, int'(req_ready), int'(g & {4{~f}}));
        check({nm, " busy"}, int'(busy), int'(g != 4'b0));
        check({nm, " wrdata"}, int'(fifo_wrdata), int'(ed));
    endtask

    initial begin
        logic [3:0] xfer, prev_g, last_g, idle_v;
        int         burst_cnt, k, found;

        rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;
        req_data = 32'hA3A2A1A0;
        next_cycle();

        // reset, single requester 2, then 3 against 0 with pointer at 3, full burst limit
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b0100, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b0100, 0, 4'b0100, 1));
        vecs.push_back(mk(1, 4'b0100, 0, 4'b0100, 1));
        vecs.push_back(mk(1, 4'b0100, 0, 4'b0100, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 4'b0100, 0));
        vecs.push_back(mk(1, 4'b1001, 0, 4'b0000, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 4'b1001, 0, 4'b1000, 1));
        vecs.push_back(mk(1, 4'b1001, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b1001, 0, 4'b0001, 1));
        // requester 1 stalled by full for 5 cycles after its 2nd word
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1));
        vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 4'b0010, 1, 4'b0010, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1));
        vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1));
        vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1));
        // requester 0 drains after 2 words; pointer 1 must skip to 3
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b1001, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b1001, 0, 4'b0001, 1));
        vecs.push_back(mk(1, 4'b1001, 0, 4'b0001, 1));
        vecs.push_back(mk(1, 4'b1000, 0, 4'b0001, 0));
        vecs.push_back(mk(1, 4'b1000, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b1000, 0, 4'b1000, 1));

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; req_valid = vecs[i].valid; fifo_full = vecs[i].full;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].wr, vecs[i].full);
            next_cycle();
        end

        // all four valid: bursts of BL in order 0,1,2,3,0 with one bubble each
        do_reset();
        req_valid = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            check_all($sformatf("rr%0d bubble", b), 4'b0000, 1'b0, 1'b0);
            next_cycle();
            for (int w = 0; w < BL; w++) begin
                @(negedge clk);
                check_all($sformatf("rr%0d w%0d", b, w), 4'(1 << (b % 4)), 1'b1, 1'b0);
                next_cycle();
            end
        end

        // async reset mid-burst of requester 1, then pointer must restart at 0
        do_reset();
        req_valid = 4'b1111;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (grant == 4'b0010) found = 1;
            else next_cycle();
        end
        check("wait grant1", found, 1);
        #2 rst_n = 1'b0;
        #1 check_all("midrst", 4'b0000, 1'b0, 1'b0);
        next_cycle();
        rst_n = 1'b1; req_valid = 4'b0101;
        @(negedge clk);
        check_all("postrst idle", 4'b0000, 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_all("postrst g0", 4'b0001, 1'b1, 1'b0);
        next_cycle();

        // random valid/full traffic against a per-requester word scoreboard
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = '0;
            exp_q[i].delete();
            exp_q[i].push_back({2'(i), seq[i]});
        end
        prev_g = '0; last_g = '0; idle_v = '0; burst_cnt = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 7);
                req_data[i*8 +: 8] = {2'(i), seq[i]};
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            xfer = req_valid & req_ready;
            check("rnd wr while full", int'(fifo_wr & fifo_full), 0);
            check("rnd ready onehot", int'($countones(req_ready) <= 1), 1);
            check("rnd grant onehot", int'($countones(grant) <= 1), 1);
            check("rnd wr vs xfer", int'(fifo_wr), int'(|xfer));
            if (grant != 4'b0 && prev_g != 4'b0 && grant != prev_g)
                check("rnd no bubble", int'(grant), int'(prev_g));
            if (grant == 4'b0) begin
                burst_cnt = 0;
                idle_v = req_valid;
            end else if (prev_g == 4'b0) begin
                if (grant == last_g && (idle_v & ~grant) != 4'b0)
                    check("rnd fairness", int'(grant), int'(idle_v & ~grant));
                last_g = grant;
            end
            if (fifo_wr) begin
                k = oh2idx(grant);
                burst_cnt++;
                check("rnd burst len", int'(burst_cnt <= BL), 1);
                if (exp_q[k].size() == 0) check("rnd sb empty", 0, 1);
                else check($sformatf("rnd data r%0d", k), int'(fifo_wrdata),
                           int'(exp_q[k].pop_front()));
            end
            for (int i = 0; i < 4; i++) begin
                if (xfer[i]) begin
                    seq[i] = seq[i] + 6'd1;
                    exp_q[i].push_back({2'(i), seq[i]});
                end
            end
            prev_g = grant;
            next_cycle();
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("rnd leftover r%0d", i), exp_q[i].size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
